keypad_scan_ctrl: RTL and testbench
===================================

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning HCLK cycles per row slot (min 4).
REQ-002 SHALL have parameter DEB_CNT, default 4, meaning consecutive matching slot samples to confirm a press or release (min 1).
REQ-003 SHALL have port HCLK  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  scan enable; high to scan.
REQ-006 SHALL have port COL  input  4  keypad column sense; active-high when a key in the driven row is pressed.
REQ-007 SHALL have port ROW  output  4  one-hot active-high row drive.
REQ-008 SHALL have port key_valid  output  1  FIFO non-empty; key_code is valid.
REQ-009 SHALL have port key_code  output  4  head-of-FIFO key code.
REQ-010 SHALL have port key_ready  input  1  consumer accepts head entry.
REQ-011 SHALL have port last_key  output  5  most recent confirmed key, zero-extended; 5'h10 means none.
REQ-012 SHALL have port fifo_count  output  3  entries held, 0..4.
REQ-013 SHALL have port overflow  output  1  sticky; a confirmed key was dropped.
REQ-014 SHALL have port clr_ovf  input  1  clears overflow.

Function
REQ-015 SHALL pass COL through a two-flop synchronizer; "sample" = synchronized COL when slot counter == SCAN_DIV-1.
REQ-016 SHALL run a slot counter 0..SCAN_DIV-1, wrapping to 0, active in SCAN/DEBOUNCE/RELEASE only; cleared in IDLE.
REQ-017 SHALL implement states IDLE, SCAN, DEBOUNCE, RELEASE.
REQ-018 IDLE: ROW=4'b0000; go to SCAN with row index 0 and counter 0 when en=1.
REQ-019 SCAN: ROW=1<<row_idx; at slot end, sample==0 -> row_idx+1 mod 4 (3 wraps to 0); sample!=0 -> DEBOUNCE with candidate col = lowest set bit index, match count 1, row held.
REQ-020 DEBOUNCE: at each slot end, lowest-set-bit index == candidate with sample!=0 -> count+1; else -> SCAN with row_idx+1 mod 4.
REQ-021 DEBOUNCE: when count reaches DEB_CNT (DEB_CNT=1 confirms in the same cycle as entry), push code = row_idx*4 + col_idx, set last_key = {1'b0,code}, go RELEASE with release count 0.
REQ-022 RELEASE: row held; at each slot end, sample==0 -> count+1, sample!=0 -> count=0; count reaching DEB_CNT -> SCAN with row_idx+1 mod 4.
REQ-023 Multiple columns pressed: lowest column index wins; other keys ignored until release.
REQ-024 en=0 in any state -> IDLE next cycle, ROW=0; FIFO, last_key, overflow retained; in-progress debounce abandoned, no push.
REQ-025 FIFO depth 4; push at confirm; pop when key_valid && key_ready; key_valid = fifo_count!=0; key_code = head, combinational from storage.
REQ-026 Push when full without pop: entry dropped, contents unchanged, overflow set next cycle.
REQ-027 Push and pop same cycle: both occur, fifo_count unchanged, no overflow, even if full.
REQ-028 Pop when empty: ignored.
REQ-029 clr_ovf clears overflow; simultaneous set and clr_ovf -> overflow stays 1.
REQ-030 Confirm-to-key_valid latency: one cycle after confirming edge; COL-to-sample latency 2 cycles.

Reset
REQ-031 RST=1 at clock edge: state IDLE, ROW=4'b0000, row_idx 0, counters 0, FIFO empty, key_valid=0, key_code=0, fifo_count=0, last_key=5'h10, overflow=0; synchronizer flops 0.
REQ-032 Reset overrides en, key_ready, clr_ovf, and any in-progress operation.

Verification (bench: SCAN_DIV=4, DEB_CNT=3)
REQ-033 Reset, en=1, COL=0 -> ROW cycles 0001,0010,0100,1000,0001 every 4 cycles; key_valid=0; last_key=5'h10.
REQ-034 COL=4'b1000 held only when ROW=0100 -> key_code=4'hB, key_valid=1, last_key=5'h0B after 3 matching slots; exactly one entry until COL=0 for 3 slots.
REQ-035 COL=4'b0110 on row 0 -> code 4'h1; COL glitching to 0 after 1 slot -> no push, scan resumes at row 1.
REQ-036 Five presses, key_ready=0 -> fifo_count=4, overflow=1, head = first code; clr_ovf pulse -> overflow=0; 4 pops return codes in order.
REQ-037 FIFO full, push coincident with key_ready=1 -> fifo_count stays 4, overflow=0, new code at tail.
REQ-038 en=0 mid-DEBOUNCE, then RST mid-RELEASE -> ROW=0 next cycle, no push; after reset all outputs at REQ-031 values.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner with slot-based debounce,
// a 4-entry key FIFO and a sticky overflow flag.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int DEB_CNT  = 4
) (
  input  logic       HCLK,
  input  logic       RST,
  input  logic       en,
  input  logic [3:0] COL,
  output logic [3:0] ROW,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic [4:0] last_key,
  output logic [2:0] fifo_count,
  output logic       overflow,
  input  logic       clr_ovf
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEB_CNT + 1);
  localparam logic [CW-1:0] SLOT_END = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DEBOUNCE,
    RELEASE
  } state_t;

  state_t        state;
  logic [CW-1:0] slot;
  logic [1:0]    row_idx;
  logic [1:0]    cand;
  logic [DW-1:0] dcnt;
  logic [3:0]    sync1;
  logic [3:0]    sync2;

  logic       slot_end;
  logic       hit;
  logic [1:0] low;
  logic [1:0] next_row;
  logic       confirm;
  logic [3:0] code;

  logic [3:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic       pop;
  logic       full;
  logic       do_push;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  always_ff @(posedge HCLK) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= COL;
      sync2 <= sync1;
    end
  end

  always_comb begin
    slot_end = (state != IDLE) && (slot == SLOT_END);
    hit      = |sync2;
    low      = lowest(sync2);
    next_row = row_idx + 2'd1;
    confirm  = 1'b0;
    if (en && slot_end && hit) begin
      if (state == SCAN && DEB_CNT == 1)
        confirm = 1'b1;
      if (state == DEBOUNCE && low == cand &&
          dcnt == DEB_LAST)
        confirm = 1'b1;
    end
    code = {row_idx, (state == SCAN) ? low : cand};
  end

  always_ff @(posedge HCLK) begin
    if (RST) begin
      state    <= IDLE;
      ROW      <= '0;
      row_idx  <= '0;
      cand     <= '0;
      dcnt     <= '0;
      slot     <= '0;
      last_key <= 5'h10;
    end else if (!en) begin
      state   <= IDLE;
      ROW     <= '0;
      row_idx <= '0;
      dcnt    <= '0;
      slot    <= '0;
    end else begin
      if (state != IDLE)
        slot <= slot_end ? '0 : slot + 1'b1;
      unique case (state)
        IDLE: begin
          state   <= SCAN;
          row_idx <= '0;
          ROW     <= 4'b0001;
        end
        SCAN: if (slot_end) begin
          if (!hit) begin
            row_idx <= next_row;
            ROW     <= 4'b0001 << next_row;
          end else if (confirm) begin
            state    <= RELEASE;
            dcnt     <= '0;
            last_key <= {1'b0, code};
          end else begin
            state <= DEBOUNCE;
            cand  <= low;
            dcnt  <= DW'(1);
          end
        end
        DEBOUNCE: if (slot_end) begin
          if (confirm) begin
            state    <= RELEASE;
            dcnt     <= '0;
            last_key <= {1'b0, code};
          end else if (hit && low == cand) begin
            dcnt <= dcnt + 1'b1;
          end else begin
            state   <= SCAN;
            row_idx <= next_row;
            ROW     <= 4'b0001 << next_row;
          end
        end
        RELEASE: if (slot_end) begin
          // any activity on the held row restarts the quiet count
          if (hit) begin
            dcnt <= '0;
          end else if (dcnt == DEB_LAST) begin
            state   <= SCAN;
            row_idx <= next_row;
            ROW     <= 4'b0001 << next_row;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign key_valid = fifo_count != 3'd0;
  assign key_code  = mem[rd_ptr];
  assign pop       = key_valid && key_ready;
  assign full      = fifo_count == 3'd4;
  assign do_push   = confirm && (!full || pop);

  always_ff @(posedge HCLK) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= code;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      fifo_count <= fifo_count + 3'(do_push) - 3'(pop);
      if (confirm && full && !pop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix, slot-level
// reference model, directed tables and random traffic.
module tb_keypad_scan_ctrl;

  localparam int SD = 4;
  localparam int DC = 3;

  logic       HCLK = 1'b0;
  logic       RST;
  logic       en;
  logic [3:0] COL;
  logic [3:0] ROW;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [4:0] last_key;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       clr_ovf;

  logic [15:0] keys;
  bit          chk_on = 0;
  int          passed = 0;
  int          total  = 0;

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEB_CNT(DC)) dut (
    .HCLK(HCLK), .RST(RST), .en(en), .COL(COL),
    .ROW(ROW), .key_valid(key_valid),
    .key_code(key_code), .key_ready(key_ready),
    .last_key(last_key), .fifo_count(fifo_count),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 HCLK = ~HCLK;

  // physical keypad: a pressed key shorts its row to its column
  always_comb begin
    COL = 4'h0;
    for (int r = 0; r < 4; r++)
      if (ROW[r] === 1'b1) COL = COL | keys[r*4 +: 4];
  end

  // reference: scanning modelled per slot on plain integers
  bit         m_on = 0;
  bit         m_lock = 0;
  int         m_tick = 0;
  int         m_row = 0;
  int         m_cand = -1;
  int         m_hits = 0;
  int         m_quiet = 0;
  int         m_last = 16;
  bit         m_ovf = 0;
  logic [3:0] m_s1 = 0;
  logic [3:0] m_s2 = 0;
  int         mq[$];

  function automatic int lowbit(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge HCLK) begin : model
    logic [3:0] col;
    logic [3:0] s;
    bit push;
    bit pop;
    bit full;
    int code;
    col  = m_on ? keys[m_row*4 +: 4] : 4'h0;
    push = 0;
    code = 0;
    if (RST) begin
      m_on = 0; m_lock = 0; m_tick = 0; m_row = 0;
      m_cand = -1; m_hits = 0; m_quiet = 0;
      m_last = 16; m_ovf = 0; m_s1 = 0; m_s2 = 0;
      mq.delete();
    end else begin
      s = m_s2;
      m_s2 = m_s1;
      m_s1 = col;
      pop  = (mq.size() != 0) && key_ready;
      full = mq.size() == 4;
      if (!en) begin
        m_on = 0; m_tick = 0; m_row = 0;
        m_cand = -1; m_lock = 0;
      end else if (!m_on) begin
        m_on = 1; m_tick = 0; m_row = 0;
        m_cand = -1; m_lock = 0;
      end else if (m_tick != SD - 1) begin
        m_tick++;
      end else begin
        m_tick = 0;
        if (m_lock) begin
          m_quiet = (s == 0) ? m_quiet + 1 : 0;
          if (m_quiet == DC) begin
            m_lock = 0;
            m_row = (m_row + 1) % 4;
          end
        end else if (s != 0 &&
                     (m_cand < 0 || lowbit(s) == m_cand)) begin
          if (m_cand < 0) begin
            m_cand = lowbit(s);
            m_hits = 1;
          end else begin
            m_hits++;
          end
          if (m_hits == DC) begin
            push = 1;
            code = m_row * 4 + m_cand;
            m_last = code;
            m_lock = 1;
            m_quiet = 0;
            m_cand = -1;
          end
        end else begin
          m_cand = -1;
          m_row = (m_row + 1) % 4;
        end
      end
      if (pop) void'(mq.pop_front());
      if (push && full && !pop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      if (push && !(full && !pop)) mq.push_back(code);
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h",
                  name, act, exp);
  endtask

  task automatic tick();
    logic [3:0] erow;
    logic [3:0] ecode;
    logic [3:0] acode;
    int n;
    @(negedge HCLK);
    if (chk_on) begin
      n = mq.size();
      erow  = m_on ? 4'(1 << m_row) : 4'h0;
      ecode = (n != 0) ? 4'(mq[0]) : 4'h0;
      acode = (n != 0) ? key_code : 4'h0;
      total++;
      if (ROW === erow && key_valid === (n != 0) &&
          fifo_count === 3'(n) &&
          last_key === 5'(m_last) &&
          overflow === m_ovf && acode === ecode)
        passed++;
      else
        $display({"FAIL model @%0t: ROW %b/%b valid %b ",
                  "cnt %0d/%0d last %h/%h ovf %b/%b ",
                  "code %h/%h"}, $time, ROW, erow,
                 key_valid, fifo_count, n, last_key,
                 m_last, overflow, m_ovf, acode, ecode);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_row(input logic [3:0] r);
    logic [3:0] prev;
    bit ok;
    ok = 0;
    prev = ROW;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (ROW === r && prev !== r) ok = 1;
      prev = ROW;
    end
    chk("wait_row_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_cnt(input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      ok = (fifo_count === 3'(n));
    end
    chk("wait_count_timeout", 32'(ok), 32'd1);
  endtask

  task automatic press(input int k);
    keys = 16'(1 << k);
    ticks(80);
    keys = '0;
    ticks(60);
  endtask

  task automatic pop_one();
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_row"}, 32'(ROW), 32'h0);
    chk({tag, "_valid"}, 32'(key_valid), 32'h0);
    chk({tag, "_code"}, 32'(key_code), 32'h0);
    chk({tag, "_count"}, 32'(fifo_count), 32'h0);
    chk({tag, "_last"}, 32'(last_key), 32'h10);
    chk({tag, "_ovf"}, 32'(overflow), 32'h0);
  endtask

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  code;
  } vec_t;

  vec_t tbl[6];
  int   ovf_codes[5];
  int   fill_codes[4];
  int   r;

  initial begin
    tbl[0] = '{16'h0800, 4'hB};
    tbl[1] = '{16'h0006, 4'h1};
    tbl[2] = '{16'h8000, 4'hF};
    tbl[3] = '{16'h0001, 4'h0};
    tbl[4] = '{16'h0030, 4'h4};
    tbl[5] = '{16'h0C00, 4'hA};
    ovf_codes  = '{2, 5, 9, 12, 14};
    fill_codes = '{3, 6, 7, 8};

    RST = 1'b1; en = 1'b0; keys = '0;
    key_ready = 1'b0; clr_ovf = 1'b0;
    repeat (3) @(negedge HCLK);
    chk_on = 1;
    chk_reset("reset");

    // idle scan sweeps every row in turn
    RST = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      chk("scan_row", 32'(ROW), 32'(1 << ((i / 4) % 4)));
    end
    chk("scan_valid", 32'(key_valid), 32'h0);
    chk("scan_last", 32'(last_key), 32'h10);

    for (int i = 0; i < 6; i++) begin
      keys = tbl[i].keys;
      wait_cnt(1);
      chk("tbl_code", 32'(key_code), 32'(tbl[i].code));
      chk("tbl_last", 32'(last_key), 32'(tbl[i].code));
      ticks(30);
      chk("tbl_held_once", 32'(fifo_count), 32'd1);
      keys = '0;
      ticks(40);
      chk("tbl_after_rel", 32'(fifo_count), 32'd1);
      pop_one();
      chk("tbl_popped", 32'(fifo_count), 32'd0);
    end

    // one-slot glitch on row 0 must not register
    wait_row(4'b0001);
    keys = 16'h0002;
    ticks(4);
    keys = '0;
    ticks(3);
    chk("glitch_row0", 32'(ROW), 32'b0001);
    tick();
    chk("glitch_row1", 32'(ROW), 32'b0010);
    ticks(40);
    chk("glitch_nopush", 32'(fifo_count), 32'd0);

    for (int i = 0; i < 5; i++) press(ovf_codes[i]);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(key_code), 32'h2);
    chk("ovf_last", 32'(last_key), 32'h0E);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order", 32'(key_code), 32'(ovf_codes[i]));
      pop_one();
    end
    chk("ovf_drained", 32'(fifo_count), 32'd0);

    // push into a full FIFO on the very cycle it is popped
    for (int i = 0; i < 4; i++) press(fill_codes[i]);
    chk("full_count", 32'(fifo_count), 32'd4);
    wait_row(4'b0001);
    keys = 16'(1 << 13);
    wait_row(4'b1000);
    ticks(11);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    chk("pp_count", 32'(fifo_count), 32'd4);
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_last", 32'(last_key), 32'h0D);
    keys = '0;
    chk("pp_head", 32'(key_code), 32'h6);
    pop_one();
    chk("pp_q1", 32'(key_code), 32'h7);
    pop_one();
    chk("pp_q2", 32'(key_code), 32'h8);
    pop_one();
    chk("pp_tail", 32'(key_code), 32'hD);
    pop_one();
    ticks(40);

    // disable mid-debounce, then reset mid-release
    wait_row(4'b0010);
    keys = 16'h0001;
    wait_row(4'b0001);
    ticks(5);
    en = 1'b0;
    tick();
    chk("en_off_row", 32'(ROW), 32'h0);
    ticks(10);
    chk("en_off_nopush", 32'(fifo_count), 32'd0);
    chk("en_off_last", 32'(last_key), 32'h0D);
    en = 1'b1;
    wait_cnt(1);
    chk("reen_last", 32'(last_key), 32'h00);
    ticks(3);
    RST = 1'b1;
    tick();
    chk_reset("midrst");
    keys = '0;
    tick();
    RST = 1'b0;
    ticks(5);

    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 9);
      if (r < 5)
        keys = 16'(1 << $urandom_range(0, 15));
      else if (r < 7)
        keys = 16'($urandom) & 16'($urandom);
      else
        keys = '0;
      key_ready = ($urandom_range(0, 3) == 0);
      clr_ovf   = ($urandom_range(0, 7) == 0);
      en        = ($urandom_range(0, 15) != 0);
      RST       = ($urandom_range(0, 60) == 0);
      if (RST) begin
        tick();
        RST = 1'b0;
      end
      ticks($urandom_range(1, 40));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
